// File: rtl/seq_det_fsm_pkg.sv
// Shared constants for the programmable count-sequence detector.
package seq_det_fsm_pkg;

  localparam int DEF_CNT_W   = 4;
  localparam int SEQ_LEN_MAX = 8;
  localparam int MATCH_IDX_W = 4;
  localparam logic [MATCH_IDX_W-1:0] IDX_IDLE = '0;

  // Zero-width safe counter width for the inter-sample gap timer.
  function automatic int gap_width(input int max_gap);
    return (max_gap < 1) ? 1 : $clog2(max_gap + 1);
  endfunction

endpackage

// File: rtl/seq_det_fsm_gap_timer.sv
// Idle-cycle counter used while a partial match is pending.
module seq_gap_timer
  import seq_det_fsm_pkg::*;
#(
  parameter int MAX_GAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic expire
);

  localparam int GAP_W = gap_width(MAX_GAP);

  logic [GAP_W-1:0] gap_q, gap_d;

  // The partial match survives MAX_GAP idle cycles; the next idle one expires it.
  assign expire = advance && (MAX_GAP != 0) && (gap_q == GAP_W'(MAX_GAP));

  always_comb begin
    gap_d = gap_q;
    if (clear || expire) gap_d = '0;
    else if (advance)    gap_d = gap_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end

endmodule

// File: rtl/seq_det_fsm.sv
// Detects a programmable sequence of SEQ_LEN valid samples, with gap timeout,
// restart-on-element-0 fallback and a saturating hit counter.
module seq_det_fsm
  import seq_det_fsm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SEQ_LEN = 3,
  parameter int MAX_GAP = 4,
  parameter int HIT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cnt_vld,
  input  logic [CNT_W-1:0]         cnt,
  input  logic [SEQ_LEN*CNT_W-1:0] pattern,
  input  logic                     hit_clr,
  output logic                     fsm_out,
  output logic [MATCH_IDX_W-1:0]   match_idx,
  output logic [HIT_W-1:0]         hit_cnt
);

  localparam logic [MATCH_IDX_W-1:0] IDX_FINAL = MATCH_IDX_W'(SEQ_LEN);
  localparam logic [HIT_W-1:0]       HIT_MAX   = '1;

  logic [MATCH_IDX_W-1:0] idx_q, idx_d;
  logic [HIT_W-1:0]       hit_q, hit_d;
  logic [CNT_W-1:0]       cur_elem;
  logic                   hit_inc, gap_clr, gap_adv, gap_exp;

  always_comb begin
    cur_elem = '0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (idx_q == MATCH_IDX_W'(i)) cur_elem = pattern[i*CNT_W +: CNT_W];
  end

  always_comb begin
    idx_d   = idx_q;
    hit_inc = 1'b0;
    gap_clr = 1'b0;
    gap_adv = 1'b0;
    if (!en) begin
      idx_d   = IDX_IDLE;
      gap_clr = 1'b1;
    end else if (cnt_vld) begin
      gap_clr = 1'b1;
      if (idx_q < IDX_FINAL && cnt == cur_elem) idx_d = idx_q + 1'b1;
      else if (cnt == pattern[CNT_W-1:0])       idx_d = MATCH_IDX_W'(1);
      else                                      idx_d = IDX_IDLE;
      hit_inc = (idx_d == IDX_FINAL);
    end else if (idx_q == IDX_FINAL) begin
      idx_d   = IDX_IDLE;
      gap_clr = 1'b1;
    end else if (idx_q == IDX_IDLE) begin
      gap_clr = 1'b1;
    end else begin
      gap_adv = 1'b1;
      if (gap_exp) idx_d = IDX_IDLE;
    end
  end

  always_comb begin
    hit_d = hit_q;
    if (hit_clr)                        hit_d = '0;
    else if (hit_inc && hit_q != HIT_MAX) hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= IDX_IDLE;
      hit_q <= '0;
    end else begin
      idx_q <= idx_d;
      hit_q <= hit_d;
    end
  end

  seq_gap_timer #(.MAX_GAP(MAX_GAP)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clr),
    .advance (gap_adv),
    .expire  (gap_exp)
  );

  assign fsm_out   = (idx_q == IDX_FINAL);
  assign match_idx = idx_q;
  assign hit_cnt   = hit_q;

endmodule

// File: tb/tb_seq_det_fsm.sv
// Directed bench for seq_det_fsm: pattern 4,5,6 with MAX_GAP=2, HIT_W=2.
module tb_seq_det_fsm;

  localparam int CNT_W = 4, SEQ_LEN = 3, MAX_GAP = 2, HIT_W = 2;

  logic                     clk = 1'b0;
  logic                     rst, en, cnt_vld, hit_clr;
  logic [CNT_W-1:0]         cnt;
  logic [SEQ_LEN*CNT_W-1:0] pattern;
  logic                     fsm_out;
  logic [3:0]               match_idx;
  logic [HIT_W-1:0]         hit_cnt;

  typedef struct {
    int              step;
    logic [3:0]      idx;
    logic            fsm;
    logic [HIT_W-1:0] hit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  seq_det_fsm #(.CNT_W(CNT_W), .SEQ_LEN(SEQ_LEN), .MAX_GAP(MAX_GAP), .HIT_W(HIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt_vld   (cnt_vld),
    .cnt       (cnt),
    .pattern   (pattern),
    .hit_clr   (hit_clr),
    .fsm_out   (fsm_out),
    .match_idx (match_idx),
    .hit_cnt   (hit_cnt)
  );

  task automatic step(input logic r, input logic e, input logic c, input logic v,
                      input int val, input int e_idx, input int e_hit);
    exp_t x, y;
    rst = r; en = e; hit_clr = c; cnt_vld = v; cnt = CNT_W'(val);
    step_no++;
    x.step = step_no;
    x.idx  = 4'(e_idx);
    x.fsm  = (e_idx == SEQ_LEN);
    x.hit  = HIT_W'(e_hit);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    y = exp_q.pop_front();
    checks++;
    assert (match_idx === y.idx) else begin
      errors++;
      $error("FAIL step%0d match_idx got %0d want %0d", y.step, match_idx, y.idx);
    end
    checks++;
    assert (fsm_out === y.fsm) else begin
      errors++;
      $error("FAIL step%0d fsm_out got %0b want %0b", y.step, fsm_out, y.fsm);
    end
    checks++;
    assert (hit_cnt === y.hit) else begin
      errors++;
      $error("FAIL step%0d hit_cnt got %0d want %0d", y.step, hit_cnt, y.hit);
    end
  endtask

  task automatic s(input logic v, input int val, input int e_idx, input int e_hit);
    step(1'b0, 1'b1, 1'b0, v, val, e_idx, e_hit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    pattern = {4'd6, 4'd5, 4'd4};
    rst = 1'b1; en = 1'b1; hit_clr = 1'b0; cnt_vld = 1'b0; cnt = '0;
    @(posedge clk); #1;
    // Reset state
    step(1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 0);
    // Case 1: clean detection, one-cycle pulse
    s(1, 4, 1, 0); s(1, 5, 2, 0); s(1, 6, 3, 1); s(0, 0, 0, 1);
    // Case 2: restart on repeated first element, then a broken stream
    s(1, 4, 1, 1); s(1, 4, 1, 1); s(1, 5, 2, 1); s(1, 6, 3, 2); s(0, 0, 0, 2);
    s(1, 4, 1, 2); s(1, 7, 0, 2); s(1, 5, 0, 2); s(1, 6, 0, 2);
    // Case 3: gap of MAX_GAP survives, MAX_GAP+1 drops
    s(1, 4, 1, 2); s(1, 5, 2, 2); s(0, 0, 2, 2); s(0, 0, 2, 2); s(1, 6, 3, 3); s(0, 0, 0, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    s(1, 4, 1, 0); s(1, 5, 2, 0); s(0, 0, 2, 0); s(0, 0, 2, 0); s(0, 0, 0, 0); s(1, 6, 0, 0);
    // Case 4: back-to-back detections
    s(1, 4, 1, 0); s(1, 5, 2, 0); s(1, 6, 3, 1); s(1, 4, 1, 1); s(1, 5, 2, 1); s(1, 6, 3, 2);
    s(0, 0, 0, 2);
    // Case 5: saturation, then clear wins over an increment
    s(1, 4, 1, 2); s(1, 5, 2, 2); s(1, 6, 3, 3);
    s(1, 4, 1, 3); s(1, 5, 2, 3); s(1, 6, 3, 3);
    s(1, 4, 1, 3); s(1, 5, 2, 3); step(1'b0, 1'b1, 1'b1, 1'b1, 6, 3, 0); s(0, 0, 0, 0);
    // Case 6: reset mid-sequence, then disable mid-sequence
    s(1, 4, 1, 0); s(1, 5, 2, 0); s(1, 6, 3, 1); s(0, 0, 0, 1);
    s(1, 4, 1, 1); s(1, 5, 2, 1); step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0); s(1, 6, 0, 0);
    s(1, 4, 1, 0); s(1, 5, 2, 0); s(1, 6, 3, 1);
    s(1, 4, 1, 1); s(1, 5, 2, 1); step(1'b0, 1'b0, 1'b0, 1'b1, 6, 0, 1); s(1, 6, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_fsm.md
Name: seq_det_fsm

Overview:
- Parametrised successor to the fixed count-sequence detector.
- Watches a stream of counter values qualified by a valid strobe and pulses an output when a programmable sequence of SEQ_LEN values arrives in consecutive valid samples.
- Adds an inter-sample gap timeout, a restart-on-first-element rule and a saturating hit counter.
- Sits beside the counter block; its output feeds status/interrupt logic.

Parameters:
- CNT_W, `CNT_W (from defines), width of each sample and each pattern element.
- SEQ_LEN, 3, number of pattern elements; legal range 1..8.
- MAX_GAP, 4, max idle cycles between valid samples inside a partial match; 0 disables the timeout.
- HIT_W, 8, width of the saturating detection counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- en  in  1  detector enable; low forces match index to 0 on the next edge, hit counter holds
- cnt_vld  in  1  sample strobe for cnt
- cnt  in  CNT_W  sample value
- pattern  in  SEQ_LEN*CNT_W  element i at bits [i*CNT_W +: CNT_W]; element 0 first; quasi-static, sampled live
- hit_clr  in  1  clears hit_cnt
- fsm_out  out  1  one-cycle detection pulse
- match_idx  out  4  current number of matched elements, 0..SEQ_LEN
- hit_cnt  out  HIT_W  saturating count of detections

Behaviour:
- State: registered match index idx in 0..SEQ_LEN. idx==0 is IDLE; idx==SEQ_LEN is FINAL.
- Gap counter gap is log2(MAX_GAP+1) bits wide.
- Reset (rst=1 at a rising edge): idx=0, gap=0, hit_cnt=0. Therefore fsm_out=0 and match_idx=0. Reset mid-sequence discards the partial match.
- Precedence at each edge: rst, then en=0 (idx=0, gap=0), then the normal rules below.
- Normal rules, with cnt_vld=1 and S=cnt:
  - If idx<SEQ_LEN and S==pattern[idx], then idx=idx+1.
  - Else if S==pattern[0], then idx=1. This is the restart rule and also applies from FINAL, so back-to-back sequences are detected.
  - Else idx=0.
  - gap=0 in all three cases.
- Normal rules, with cnt_vld=0:
  - From FINAL: idx=0. fsm_out is strictly one cycle.
  - From idx==0: hold, gap=0.
  - Otherwise: gap=gap+1. If MAX_GAP!=0 and gap==MAX_GAP, then idx=0 and gap=0 instead. That is, the partial match survives exactly MAX_GAP idle cycles and is dropped on the (MAX_GAP+1)th.
- Fallback is restart-on-element-0 only. No full prefix (KMP) fallback. Example: pattern 4,4,5 with stream 4,4,4,5 is not detected. This is the decided behaviour.
- SEQ_LEN==1: any valid sample equal to pattern[0] takes idx to FINAL.
- fsm_out = (idx==SEQ_LEN). It is combinational decode of registered state and is glitch-free.
- Latency: fsm_out is high in the cycle immediately after the edge that accepts the last element.
- hit_cnt:
  - Increments at the edge where idx enters FINAL.
  - Saturates at 2^HIT_W-1.
  - hit_clr has priority over a simultaneous increment; the result is 0.
  - en=0 does not clear it.
- match_idx is idx, zero-extended to 4 bits.

Decomposition:
- Add to the shared defines:
  - the legal SEQ_LEN maximum (8)
  - the match_idx width (4)
  - the IDLE index constant (0)
- One natural sub-module: seq_gap_timer. It holds the gap counter, with inputs clear/advance and output expire. The FSM and hit counter stay in the top.

Test Plan:
All cases use CNT_W=4, SEQ_LEN=3, pattern={6,5,4} (element0=4), MAX_GAP=2, HIT_W=2, en=1.
1. Valid 4,5,6 on consecutive cycles -> match_idx 1,2,3; fsm_out high exactly one cycle after the 6 edge; hit_cnt=1; idx=0 next cycle.
2. Valid 4,4,5,6 -> second 4 restarts at idx=1; detection as in case 1; stream 4,7,5,6 -> no pulse, idx ends 0.
3. Valid 4,5, then 2 idle cycles, then 6 -> detect. Valid 4,5, then 3 idle cycles, then 6 -> idx drops to 0 after the third idle cycle, no pulse.
4. Valid 4,5,6,4,5,6 back-to-back -> two one-cycle pulses three cycles apart; hit_cnt=2.
5. Four full detections -> hit_cnt saturates at 3 and stays; hit_clr pulsed in the same cycle as a fifth detection -> hit_cnt=0.
6. Valid 4,5, then rst=1 for one edge -> idx=0, hit_cnt=0, fsm_out=0; a following 6 gives no pulse. Repeat with en=0 instead of rst -> idx=0, hit_cnt unchanged.
